// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and a width helper.
package serial_sub_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } state_t;

  // Smallest r with 2**r >= v.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/serial_sub_full_sub.sv
// One-bit full subtractor cell: diff = a - b - cin, borrow out.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic diff,
  output logic borrow
);
  assign diff   = a ^ b ^ cin;
  assign borrow = (~a & b) | (~(a ^ b) & cin);
endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first through one full_sub cell.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output 'ovf'.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = clog2(WIDTH);

  state_t           state, nstate;
  logic [WIDTH-1:0] a_sr, b_sr, res;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             cell_d, cell_b;
  logic             last;

  full_sub u_cell (
    .a      (a_sr[0]),
    .b      (b_sr[0]),
    .cin    (brw),
    .diff   (cell_d),
    .borrow (cell_b)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:  if (start) nstate = S_SHIFT;
      S_SHIFT: if (last)  nstate = S_DONE;
      S_DONE:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res        <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          a_sr <= a;
          b_sr <= b;
          brw  <= 1'b0;
          cnt  <= '0;
          busy <= 1'b1;
        end
        S_SHIFT: begin
          // Result bits enter at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
          res  <= WIDTH'({cell_d, res} >> 1);
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          brw  <= cell_b;
          cnt  <= cnt + CW'(1);
          if (last) begin
            diff       <= WIDTH'({cell_d, res} >> 1);
            borrow_out <= cell_b;
            done       <= 1'b1;
            busy       <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            // On the last bit the cell is looking at the operand MSBs.
            ovf        <= (a_sr[0] ^ b_sr[0]) & (cell_d ^ a_sr[0]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed table, corner sequences, random vs. arithmetic model.
module tb_serial_sub;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a, b, diff;
  logic         busy, done, borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  serial_sub #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: plain unsigned subtraction one bit wider; the extra bit is the borrow.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    return {1'b0, x} - {1'b0, y};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int d;
    d = int'($signed(x)) - int'($signed(y));
    return (d > 127) || (d < -128);
  endfunction

  // Launch one operation and wait (bounded) for done; checks latency, busy, one-cycle done.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input string nm,
                        output logic [W-1:0] gd, output logic gb);
    int k;
    @(negedge clk); a = x; b = y; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({nm, " busy"}, busy, 1);
    a = W'($urandom); b = W'($urandom);
    k = 0;
    while (!done && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " latency"}, k, W);
    chk({nm, " busy_at_done"}, busy, 0);
    gd = diff;
    gb = borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    chk({nm, " ovf"}, ovf, ref_ovf(x, y));
`endif
    @(negedge clk);
    chk({nm, " done_1cyc"}, done, 0);
    chk({nm, " diff_held"}, diff, gd);
  endtask

  typedef struct {
    logic [W-1:0] a, b, d;
    logic         bo;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [W-1:0] gd, x, y;
    logic         gb;
    logic [W:0]   e;
    int           nd;

    tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
    tbl[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    tbl[3] = '{8'hAA, 8'hAA, 8'h00, 1'b0};
    tbl[4] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    tbl[5] = '{8'hFF, 8'h00, 8'hFF, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset diff", diff, 0);
    chk("reset borrow", borrow_out, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, $sformatf("vec%0d", i), gd, gb);
      chk($sformatf("vec%0d diff", i), gd, tbl[i].d);
      chk($sformatf("vec%0d borrow", i), gb, tbl[i].bo);
    end

    // Second start during SHIFT must be dropped.
    @(negedge clk); a = 8'h10; b = 8'h01; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(negedge clk); start = 1'b0;
    nd = 0; gd = '0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin nd++; gd = diff; end
      @(negedge clk);
    end
    chk("ignore_start dones", nd, 1);
    chk("ignore_start diff", gd, 8'h0F);

    // Reset mid-SHIFT aborts with no done pulse.
    @(negedge clk); a = 8'h05; b = 8'h03; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort diff", diff, 0);
    chk("abort borrow", borrow_out, 0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("abort no_done", nd, 0);
    run_op(8'h09, 8'h04, "after_abort", gd, gb);
    chk("after_abort diff", gd, 8'h05);

    // Reset and start together: reset wins.
    @(negedge clk); a = 8'h22; b = 8'h11; start = 1'b1; rst = 1'b1;
    @(negedge clk); start = 1'b0; rst = 1'b0;
    chk("rst_start busy", busy, 0);

`ifdef SERIAL_SUB_OVF_EN
    run_op(8'h80, 8'h01, "ovf_a", gd, gb);
    chk("ovf_a diff", gd, 8'h7F);
    chk("ovf_a flag", ovf, 1);
    run_op(8'h7F, 8'h01, "ovf_b", gd, gb);
    chk("ovf_b diff", gd, 8'h7E);
    chk("ovf_b flag", ovf, 0);
`endif

    for (int i = 0; i < 25; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      e = ref_sub(x, y);
      run_op(x, y, $sformatf("rnd%0d", i), gd, gb);
      chk($sformatf("rnd%0d diff", i), gd, e[W-1:0]);
      chk($sformatf("rnd%0d borrow", i), gb, e[W]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
